// File: rtl/div_seq.sv
// Radix-2 restoring shift-subtract integer divider, signed or unsigned, for the ALU execute stage.
// Latency: fixed WIDTH+1 cycles from the start-sampling edge to done, for every operand value.
// Backpressure: none; start is honoured only while idle, and a start seen while busy is dropped.
//
// Ports:
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   start, signed_op             request and mode, sampled together while idle
//   dividend, divisor            operands, sampled with start
//   busy, done                   operation in flight / one-cycle completion pulse
//   division_hi_rem              remainder (HI), held until the next completion
//   division_lo_quo              quotient (LO), held until the next completion
//   div0, ovf                    divide-by-zero and signed MIN/-1 flags of the last operation
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] division_hi_rem,
    output logic [WIDTH-1:0] division_lo_quo,
    output logic             div0,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    // Stored partial remainder is always below |divisor| between iterations,
    // so WIDTH bits suffice; the extra bit only appears in the shifted value.
    logic [WIDTH-1:0] rem_q, rem_d;
    // Holds the not-yet-consumed dividend bits (top) and the quotient bits
    // produced so far (bottom); one shift per iteration.
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div0_pend_q, div0_pend_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;

    logic             last_iter;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        div0_pend_d = div0_pend_q;
        ovf_pend_d  = ovf_pend_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        div0_d      = div0_q;
        ovf_d       = ovf_q;

        // Negating MIN yields MIN, which read as unsigned is exactly |MIN|.
        dvd_abs   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        rem_shift = {rem_q, quo_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d       = '0;
                    quo_d       = dvd_abs;
                    dvs_d       = dvs_abs;
                    dvd_d       = dividend;
                    q_neg_d     = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d     = signed_op & dividend[WIDTH-1];
                    div0_pend_d = (divisor == '0);
                    ovf_pend_d  = signed_op & (dividend == MIN_VAL) & (divisor == '1);
                    cnt_d       = '0;
                end
            end
            S_CALC: begin
                // The true difference is below |divisor|, so WIDTH-bit
                // arithmetic is exact once the compare has passed.
                if (rem_shift >= {1'b0, dvs_q}) begin
                    rem_d = rem_shift[WIDTH-1:0] - dvs_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                done_d = 1'b1;
                div0_d = div0_pend_q;
                ovf_d  = ovf_pend_q;
                if (div0_pend_q) begin
                    lo_d = '1;
                    hi_d = dvd_q;
                end else begin
                    // MIN / -1 falls out naturally as quotient MIN, remainder 0.
                    lo_d = q_neg_q ? -quo_q : quo_q;
                    hi_d = r_neg_q ? -rem_q : rem_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div0_pend_q <= 1'b0;
            ovf_pend_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            div0_pend_q <= div0_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
        end
    end

    assign done            = done_q;
    assign division_hi_rem = hi_q;
    assign division_lo_quo = lo_q;
    assign div0            = div0_q;
    assign ovf             = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: the driver predicts each accepted request from
// plain signed/unsigned arithmetic; a negedge monitor checks busy, every done
// pulse (latency, quotient, remainder, flags) and output stability.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    logic         ovf;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         d0;
        logic         ov;
        int           e0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   next_free = 0;
    int   last_e0 = -1000;
    int   checks = 0;
    int   failures = 0;
    logic [2*W+1:0] prev_out = '0;

    div_seq #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .signed_op       (signed_op),
        .dividend        (dividend),
        .divisor         (divisor),
        .busy            (busy),
        .done            (done),
        .division_hi_rem (hi),
        .division_lo_quo (lo),
        .div0            (div0),
        .ovf             (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating division from native arithmetic, flags from their definitions.
    function automatic exp_t ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
        exp_t   r;
        longint sa;
        longint sbv;
        r.e0 = e0;
        r.d0 = (b == 0);
        r.ov = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else if (s) begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            r.lo = 32'(sa / sbv);
            r.hi = 32'(sa % sbv);
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    // Drive one cycle's inputs at the negedge; a start is accepted only when
    // no earlier operation is still occupying the divider.
    task automatic drive_cycle(input logic st, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int e;
        @(negedge clk);
        start     = st;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        e = cyc + 1;
        if (st && reset_n && e >= next_free) begin
            sb.push_back(ref_div(s, a, b, e));
            next_free = e + W + 2;
            last_e0   = e;
        end
    endtask

    task automatic idle1();
        drive_cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        drive_cycle(1'b1, s, a, b);
        repeat (W + 1) idle1();
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_out = '0;
        end else begin
            chk("busy", busy, (cyc - last_e0 >= 0) && (cyc - last_e0 <= W));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", cyc - mon_e.e0, W + 1);
                    chk("quotient", lo, mon_e.lo);
                    chk("remainder", hi, mon_e.hi);
                    chk("div0", div0, mon_e.d0);
                    chk("ovf", ovf, mon_e.ov);
                end
            end else begin
                chk("hold", {hi, lo, div0, ovf}, prev_out);
                if (sb.size() > 0 && (cyc - sb[0].e0 > W + 1)) begin
                    chk("done_timeout", done, 1'b1);
                    sb.delete(0);
                end
            end
            prev_out = {hi, lo, div0, ovf};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset_n   = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1 reset_n = 1'b0;
        #1 chk("reset_state", {busy, done, div0, ovf, hi, lo}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        op(1'b0, 32'd100, 32'd7);
        op(1'b1, 32'hFFFF_FFF9, 32'd2);
        op(1'b1, 32'd7, 32'hFFFF_FFFE);
        op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        op(1'b0, 32'hFFFF_FFF9, 32'd2);
        op(1'b0, 32'd5, 32'd0);
        op(1'b0, 32'd10, 32'd3);
        op(1'b1, 32'hFFFF_FFFB, 32'd0);
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start during an operation is ignored
        drive_cycle(1'b1, 1'b0, 32'd1000, 32'd7);
        repeat (9) idle1();
        drive_cycle(1'b1, 1'b1, 32'd55, 32'hFFFF_FFFB);
        repeat (W + 1 - 10) idle1();

        // Start held high: restarts on every idle cycle
        repeat (2 * (W + 2) + 3) drive_cycle(1'b1, 1'b0, 32'd1000, 32'd9);
        repeat (W + 2) idle1();

        // Randomized operations, mostly back-to-back
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 200);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            op(rs, ra, rb);
            repeat ($urandom_range(0, 2)) idle1();
        end

        // Reset 15 cycles into an operation aborts it
        drive_cycle(1'b1, 1'b0, 32'd12345, 32'd11);
        repeat (14) idle1();
        @(posedge clk);
        #2 reset_n = 1'b0;
        sb.delete();
        next_free = 0;
        last_e0   = -1000;
        #1 chk("reset_async", {busy, done, div0, ovf, hi, lo}, '0);
        repeat (3) idle1();
        reset_n = 1'b1;
        op(1'b1, 32'hFFFF_FF9C, 32'd7);

        repeat (W + 3) idle1();
        chk("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle, parametrised integer divider for the ALU execute stage. It replaces the combinational repeated-subtraction divider with a radix-2 restoring shift-subtract engine, so latency is fixed at WIDTH+1 cycles regardless of operand values. It supports signed and unsigned operands through a start/busy/done handshake. Results feed the HI (remainder) and LO (quotient) registers. Divide-by-zero and signed overflow are defined and flagged.

## Interface
- WIDTH, 32, operand and result width in bits; any value ≥ 2.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- division_hi_rem  output  WIDTH  remainder.
- division_lo_quo  output  WIDTH  quotient.
- div0  output  1  last operation had divisor == 0.
- ovf  output  1  last operation was signed MIN / -1.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE** with start = 1:
  - Capture the absolute values of the operands; absolute value applies only when signed_op = 1 and the operand MSB = 1.
  - Record quotient sign q_neg = signed_op & (dividend MSB ^ divisor MSB).
  - Record remainder sign r_neg = signed_op & dividend MSB.
  - Record div0 = (divisor == 0) and ovf = signed_op & dividend == {1,0…} & divisor == all-ones.
  - Clear the iteration counter; go to CALC.
- **CALC**, one quotient bit per cycle, WIDTH cycles, MSB first:
  - Shift the partial remainder left, bringing in the next dividend bit.
  - If partial remainder ≥ |divisor|: subtract it, quotient bit = 1; otherwise quotient bit = 0.
  - The partial remainder is WIDTH+1 bits wide so the compare never overflows.
  - After the WIDTH-th iteration go to FIX.
- **FIX**, one cycle; writes the outputs, pulses done, returns to IDLE:
  - Quotient = q_neg ? -q : q; remainder = r_neg ? -r : r. Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - div0 overrides: quotient = all ones, remainder = original dividend, in both signed and unsigned mode.
  - ovf needs no override. Natural arithmetic yields quotient = MIN and remainder = 0; only the flag is raised.
- div0 and ovf are updated only in FIX and hold until the next FIX.
- start while busy is ignored; no queueing.
- Operand inputs may change freely after the sampling edge.

## Timing
- Reset, asynchronous and active-low:
  - State returns to IDLE; the iteration counter clears.
  - busy = 0, done = 0, division_hi_rem = 0, division_lo_quo = 0, div0 = 0, ovf = 0.
  - Asserting reset mid-operation aborts the division. No done is produced.
- Let edge E0 sample start.
  - busy = 1 from E0.
  - CALC iterations occur at edges E1 … E_WIDTH.
  - FIX updates outputs at edge E_(WIDTH+1). At that edge done = 1 and busy = 0.
  - Latency is WIDTH+1 cycles (33 for WIDTH = 32) for all operand values, including div0.
- done is high for exactly one cycle. Result outputs hold their value until the next FIX.
- Back-to-back: start high in the cycle done is high is accepted, since the state is IDLE. The next done follows WIDTH+1 cycles later.
- start held high continuously restarts an operation on every IDLE cycle. This is legal.
- Results do not change while busy; stale values remain visible until FIX.

## Test plan
- Unsigned 100 / 7, WIDTH = 32: lo = 14, hi = 2, done exactly 33 cycles after the start edge, busy high 33 cycles.
- Signed sign matrix:
  - -7 / 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - 7 / -2: lo = 0xFFFFFFFD, hi = 1.
  - -7 / -2: lo = 3, hi = 0xFFFFFFFF.
  - Unsigned 0xFFFFFFF9 / 2: lo = 0x7FFFFFFC, hi = 1.
- Divide by zero:
  - 5 / 0: lo = 0xFFFFFFFF, hi = 5, div0 = 1, ovf = 0, latency still 33.
  - Next op 10 / 3: div0 returns to 0.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, ovf = 1. The same operands unsigned give lo = 0, hi = 0x80000000, ovf = 0.
- Handshake:
  - A second start with different operands at cycle 10 of an operation is ignored; the result matches the first operands.
  - Start in the done cycle runs back-to-back and produces a second done 33 cycles later.
- Reset at cycle 15 of an operation: all outputs 0 immediately without a clock edge, no done pulse. A fresh start after release gives the correct result.
